// File: rtl/hysteresis_thresholder_pkg.sv
// Shared types and constants for the Canny hysteresis thresholding stage.
// Frame geometry helpers are functions so each instance can size itself from its own parameters.
package hysteresis_pkg;

    typedef enum logic {
        PROLOGUE = 1'b0,
        RUN      = 1'b1
    } state_e;

    localparam logic [7:0] EDGE_VAL     = 8'hFF;
    localparam logic [7:0] NON_EDGE_VAL = 8'h00;

    localparam int DEFAULT_WIDTH  = 720;
    localparam int DEFAULT_HEIGHT = 540;

    function automatic int shiftRegLen(input int width);
        return 2 * width + 3;
    endfunction

    function automatic int pixelCount(input int width, input int height);
        return width * height;
    endfunction

    localparam int SHIFT_REG_LEN = shiftRegLen(DEFAULT_WIDTH);
    localparam int PIXEL_COUNT   = pixelCount(DEFAULT_WIDTH, DEFAULT_HEIGHT);

endpackage

// File: rtl/hysteresis_thresholder_if.sv
// FIFO-side signals of the thresholder: pops from the NMS FIFO, pushes to the edge-map FIFO.
// master is the thresholder itself; slave is the FIFO pair (or a bench standing in for it).
interface hysteresis_thresholder_if;

    logic       in_rd_en;
    logic       in_empty;
    logic [7:0] in_dout;
    logic       out_wr_en;
    logic       out_full;
    logic [7:0] out_din;

    modport master (
        output in_rd_en,
        output out_wr_en,
        output out_din,
        input  in_empty,
        input  in_dout,
        input  out_full
    );

    modport slave (
        input  in_rd_en,
        input  out_wr_en,
        input  out_din,
        output in_empty,
        output in_dout,
        output out_full
    );

endinterface

// File: rtl/hysteresis_thresholder_classifier.sv
// Combinational double-threshold decision for one 3x3 window (index 4 is the centre).
// Single pass: a weak centre only becomes an edge if a raw neighbour is itself strong.
module hysteresis_classifier
    import hysteresis_pkg::*;
#(
    parameter int unsigned HIGH_THRESH = 48,
    parameter int unsigned LOW_THRESH  = 12
) (
    input  logic [7:0] win_i [9],
    input  logic       border_i,
    output logic [7:0] result_o
);

    localparam logic [7:0] HIGH_B = 8'(HIGH_THRESH);
    localparam logic [7:0] LOW_B  = 8'(LOW_THRESH);

    logic strongNbr;

    always_comb begin
        strongNbr = 1'b0;
        for (int i = 0; i < 9; i++) begin
            if (i != 4 && win_i[i] >= HIGH_B) begin
                strongNbr = 1'b1;
            end
        end

        result_o = NON_EDGE_VAL;
        if (!border_i) begin
            if (win_i[4] >= HIGH_B) begin
                result_o = EDGE_VAL;
            end else if (win_i[4] >= LOW_B && strongNbr) begin
                result_o = EDGE_VAL;
            end
        end
    end

endmodule

// File: rtl/hysteresis_thresholder.sv
// Streaming hysteresis thresholder: a 2*WIDTH+3 byte line shift register supplies a 3x3 window
// around the centre pixel, producing one binary edge result per input pixel in raster order.
module hysteresis_thresholder
    import hysteresis_pkg::*;
#(
    parameter int          WIDTH       = 720,
    parameter int          HEIGHT      = 540,
    parameter int unsigned HIGH_THRESH = 48,
    parameter int unsigned LOW_THRESH  = 12
) (
    input  logic                      clock,
    input  logic                      reset,
    hysteresis_thresholder_if.master  bus
);

    localparam int SR_LEN = shiftRegLen(WIDTH);
    localparam int NPIX   = pixelCount(WIDTH, HEIGHT);
    localparam int CNT_W  = $clog2(NPIX + 1);
    localparam int COL_W  = $clog2(WIDTH);
    localparam int ROW_W  = $clog2(HEIGHT);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   rdCnt_q, rdCnt_d;
    logic [COL_W-1:0]   col_q, col_d;
    logic [ROW_W-1:0]   row_q, row_d;
    logic [7:0]         shreg_q [SR_LEN];

    logic               shiftEn;
    logic               clearAll;
    logic [7:0]         shiftIn;
    logic [7:0]         win [9];
    logic               border;
    logic               readsLeft;
    logic               advance;
    logic               lastPixel;
    logic [7:0]         classResult;

    always_comb begin
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                win[r*3 + c] = shreg_q[r*WIDTH + c];
            end
        end
    end

    assign border    = (row_q == '0) || (row_q == ROW_W'(HEIGHT - 1)) ||
                       (col_q == '0) || (col_q == COL_W'(WIDTH - 1));
    assign readsLeft = (rdCnt_q != CNT_W'(NPIX));
    assign lastPixel = (row_q == ROW_W'(HEIGHT - 1)) && (col_q == COL_W'(WIDTH - 1));
    // Once every pixel is read, the tail of the frame drains without waiting on the input FIFO.
    assign advance   = !bus.out_full && (!bus.in_empty || !readsLeft);

    hysteresis_classifier #(
        .HIGH_THRESH (HIGH_THRESH),
        .LOW_THRESH  (LOW_THRESH)
    ) u_classifier (
        .win_i    (win),
        .border_i (border),
        .result_o (classResult)
    );

    always_comb begin
        state_d       = state_q;
        rdCnt_d       = rdCnt_q;
        col_d         = col_q;
        row_d         = row_q;
        shiftEn       = 1'b0;
        shiftIn       = 8'h00;
        clearAll      = 1'b0;
        bus.in_rd_en  = 1'b0;
        bus.out_wr_en = 1'b0;
        bus.out_din   = NON_EDGE_VAL;

        if (reset) begin
            unique case (state_q)
                PROLOGUE: begin
                    if (!bus.in_empty) begin
                        bus.in_rd_en = 1'b1;
                        shiftEn      = 1'b1;
                        shiftIn      = bus.in_dout;
                        rdCnt_d      = rdCnt_q + 1'b1;
                        if (rdCnt_q == CNT_W'(WIDTH + 1)) begin
                            state_d = RUN;
                        end
                    end
                end
                RUN: begin
                    if (advance) begin
                        bus.out_wr_en = 1'b1;
                        bus.out_din   = classResult;
                        shiftEn       = 1'b1;
                        if (readsLeft) begin
                            bus.in_rd_en = 1'b1;
                            shiftIn      = bus.in_dout;
                            rdCnt_d      = rdCnt_q + 1'b1;
                        end
                        if (lastPixel) begin
                            state_d  = PROLOGUE;
                            clearAll = 1'b1;
                            rdCnt_d  = '0;
                            col_d    = '0;
                            row_d    = '0;
                        end else if (col_q == COL_W'(WIDTH - 1)) begin
                            col_d = '0;
                            row_d = row_q + 1'b1;
                        end else begin
                            col_d = col_q + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Frame position and control state.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= PROLOGUE;
            rdCnt_q <= '0;
            col_q   <= '0;
            row_q   <= '0;
        end else begin
            state_q <= state_d;
            rdCnt_q <= rdCnt_d;
            col_q   <= col_d;
            row_q   <= row_d;
        end
    end

    // Line buffer: oldest byte at index 0, newest enters at the top.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < SR_LEN; i++) begin
                shreg_q[i] <= 8'h00;
            end
        end else if (clearAll) begin
            for (int i = 0; i < SR_LEN; i++) begin
                shreg_q[i] <= 8'h00;
            end
        end else if (shiftEn) begin
            for (int i = 0; i < SR_LEN - 1; i++) begin
                shreg_q[i] <= shreg_q[i+1];
            end
            shreg_q[SR_LEN-1] <= shiftIn;
        end
    end

endmodule
